freepdk45_sram_1w1r_fifo_ctrl: RTL and testbench

//  FIFO controller sequencing one 1w1r SRAM macro (write port 0, read port 1, both on clk).

---
 rtl/freepdk45_sram_1w1r_fifo_ctrl_if.sv | 13 +
 rtl/freepdk45_sram_1w1r_fifo_ctrl.sv | 83 ++++++++
 tb/tb_freepdk45_sram_1w1r_fifo_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/freepdk45_sram_1w1r_fifo_ctrl_if.sv
// freepdk45_sram_1w1r_fifo_ctrl_if: push/pop valid-ready streams of the SRAM FIFO controller
interface freepdk45_sram_1w1r_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 120
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/freepdk45_sram_1w1r_fifo_ctrl.sv
// freepdk45_sram_1w1r_fifo_ctrl: FIFO over a 1w1r SRAM macro with a 2-entry prefetch buffer; SRAM_FIFO_BYPASS_EN lets pushes skip the macro when it is empty
module freepdk45_sram_1w1r_fifo_ctrl #(
  parameter int DATA_WIDTH = 120,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  freepdk45_sram_1w1r_fifo_ctrl_if.slave        bus,
  output logic [ADDR_WIDTH:0]                   count,
  output logic                                  sram_csb0,
  output logic [ADDR_WIDTH-1:0]                 sram_addr0,
  output logic [DATA_WIDTH-1:0]                 sram_din0,
  output logic                                  sram_csb1,
  output logic [ADDR_WIDTH-1:0]                 sram_addr1,
  input  logic [DATA_WIDTH-1:0]                 sram_dout1
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  rd_inflight, live;
  logic [1:0]            obuf_cnt, obuf_cnt_n;
  logic [DATA_WIDTH-1:0] ob0, ob1, ob0_n, ob1_n, cap_d;
  logic                  push, pop, byp, wr, rd, cap, slot;
  // Handshakes and macro port decisions, all from pre-edge state.
  always_comb begin
    bus.in_ready = live && !flush && (ram_cnt < (ADDR_WIDTH+1)'(DEPTH));
    push         = bus.in_valid && bus.in_ready;
    pop          = bus.out_valid && bus.out_ready;
`ifdef SRAM_FIFO_BYPASS_EN
    byp          = push && ram_cnt == '0 && !rd_inflight && obuf_cnt != 2'd2;
`else
    byp          = 1'b0;
`endif
    wr           = push && !byp;
    rd           = !flush && ram_cnt != '0 && (obuf_cnt + {1'b0, rd_inflight}) < 2'd2;
    cap          = rd_inflight || byp;
    cap_d        = rd_inflight ? sram_dout1 : bus.in_data;
    slot         = (obuf_cnt - {1'b0, pop}) == 2'd1;
    ob0_n        = (cap && !slot) ? cap_d : pop ? ob1 : ob0;
    ob1_n        = (cap && slot) ? cap_d : ob1;
    obuf_cnt_n   = obuf_cnt + {1'b0, cap} - {1'b0, pop};
  end
  assign bus.out_valid = obuf_cnt != 2'd0;
  assign bus.out_data  = ob0;
  assign count         = ram_cnt + (ADDR_WIDTH+1)'(rd_inflight) + (ADDR_WIDTH+1)'(obuf_cnt);
  assign sram_csb0     = !wr;
  assign sram_addr0    = wr_ptr;
  assign sram_din0     = bus.in_data;
  assign sram_csb1     = !rd;
  assign sram_addr1    = rd_ptr;
  // Pointer, occupancy and output-buffer state; flush clears everything at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      obuf_cnt    <= '0;
      ob0         <= '0;
      ob1         <= '0;
    end else if (flush) begin
      live        <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      obuf_cnt    <= '0;
    end else begin
      live        <= 1'b1;
      wr_ptr      <= wr_ptr + ADDR_WIDTH'(wr);
      rd_ptr      <= rd_ptr + ADDR_WIDTH'(rd);
      ram_cnt     <= ram_cnt + (ADDR_WIDTH+1)'(wr) - (ADDR_WIDTH+1)'(rd);
      rd_inflight <= rd;
      obuf_cnt    <= obuf_cnt_n;
      ob0         <= ob0_n;
      ob1         <= ob1_n;
    end
  end
  // Empty blocks reads and full blocks writes, so both ports never hit one row together.
  assert property (@(posedge clk) disable iff (!rst_n) !(!sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1));
endmodule

// File: tb/tb_freepdk45_sram_1w1r_fifo_ctrl.sv
// tb_freepdk45_sram_1w1r_fifo_ctrl: directed bench with a behavioural 1w1r macro and an in-order scoreboard
module tb_freepdk45_sram_1w1r_fifo_ctrl;
  localparam int DW = 120;
  localparam int AW = 5;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [AW:0]   count;
  logic          sram_csb0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout1;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] q [$];
  logic [DW-1:0] a5;
  int            tests = 0;
  int            fails = 0;
  int            pushed = 0;
  int            popped = 0;
  int            n;
  int            base;
  freepdk45_sram_1w1r_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();
  freepdk45_sram_1w1r_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave), .count(count),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );
  always #5 clk = ~clk;
  // Macro model: registered read, data available for capture one edge later.
  always @(posedge clk) begin
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    logic [DW-1:0] e;
    @(negedge clk);
    chk("collision", DW'(!sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1), '0);
    if (bus.out_valid && bus.out_ready) begin
      tests++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL pop_empty observed=%0h expected=no_pop", bus.out_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pop_data", bus.out_data, e);
      end
      popped++;
    end
    if (bus.in_valid && bus.in_ready) begin
      q.push_back(bus.in_data);
      pushed++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input int bound);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < bound && q.size() != 0; i++) cyc();
    tests++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL drain_timeout observed=%0d expected=0", q.size());
    end
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_in_ready", DW'(bus.in_ready), '0);
    chk("rst_out_valid", DW'(bus.out_valid), '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_count", DW'(count), '0);
    chk("rst_csb0", DW'(sram_csb0), DW'(1));
    chk("rst_csb1", DW'(sram_csb1), DW'(1));
    #19 rst_n = 1'b1;
    #1 chk("rel_in_ready_before_edge", DW'(bus.in_ready), '0);
    @(posedge clk);
    #1 chk("rel_in_ready_after_edge", DW'(bus.in_ready), DW'(1));
    chk("idle_count", DW'(count), '0);
    bus.in_valid = 1'b1;
    n = 0;
    while (q.size() < 34 && n < 200) begin
      bus.in_data = DW'(q.size());
      cyc();
      n++;
    end
    bus.in_valid = 1'b0;
    #1;
    chk("full_count", DW'(count), DW'(34));
    chk("full_in_ready", DW'(bus.in_ready), '0);
    chk("full_pushed", DW'(pushed), DW'(34));
    drain(200);
    chk("drain_count", DW'(count), '0);
    chk("drain_popped", DW'(popped), DW'(34));
    a5 = {15{8'hA5}};
    bus.in_data   = a5;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
`ifdef SRAM_FIFO_BYPASS_EN
    #1 chk("lat_n1_valid", DW'(bus.out_valid), DW'(1));
    chk("lat_n1_data", bus.out_data, a5);
`else
    #1 chk("lat_n1_valid", DW'(bus.out_valid), '0);
    chk("lat_n1_csb1", DW'(sram_csb1), '0);
    cyc();
    chk("lat_n2_valid_pre", DW'(bus.out_valid), '0);
    cyc();
    chk("lat_n2_valid", DW'(bus.out_valid), DW'(1));
    chk("lat_n2_data", bus.out_data, a5);
`endif
    drain(10);
    chk("lat_count", DW'(count), '0);
    base = pushed;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_data = DW'(1000 + pushed);
      cyc();
    end
    chk("stream_wrap", DW'(pushed - base > 40), DW'(1));
    drain(100);
    chk("stream_count", DW'(count), '0);
    chk("stream_balance", DW'(popped), DW'(pushed));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (count != 34 && n < 100) begin
      bus.in_data = DW'(2000 + pushed);
      cyc();
      n++;
    end
    chk("full2_count", DW'(count), DW'(34));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.in_data = DW'(2000 + pushed);
      cyc();
    end
    drain(200);
    chk("full2_drain_count", DW'(count), '0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = DW'(3000 + pushed);
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (sram_csb1 && n < 10) begin
      cyc();
      n++;
    end
    chk("flush_issue_seen", DW'(sram_csb1), '0);
    bus.out_ready = 1'b0;
    cyc();
    flush = 1'b1;
    #1 chk("flush_in_ready", DW'(bus.in_ready), '0);
    chk("flush_csb1", DW'(sram_csb1), DW'(1));
    cyc();
    flush = 1'b0;
    q.delete();
    #1 chk("flush_count", DW'(count), '0);
    chk("flush_out_valid", DW'(bus.out_valid), '0);
    chk("flush_in_ready_after", DW'(bus.in_ready), DW'(1));
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = DW'(4000 + pushed);
      cyc();
    end
    #2 rst_n = 1'b0;
    #1 chk("arst_count", DW'(count), '0);
    chk("arst_out_valid", DW'(bus.out_valid), '0);
    chk("arst_in_ready", DW'(bus.in_ready), '0);
    chk("arst_csb0", DW'(sram_csb0), DW'(1));
    q.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("arst_in_ready_after", DW'(bus.in_ready), DW'(1));
    base = popped;
    bus.in_data  = DW'(120'h77);
    bus.in_valid = 1'b1;
    cyc();
    drain(20);
    chk("arst_one_pop", DW'(popped - base), DW'(1));
    chk("arst_final_count", DW'(count), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
